// File: rtl/aes_block_adapter_if.sv
// Stream/block handshake bundle for aes_block_adapter.
//   pt_*   : 32-bit plaintext words in from the source streamer
//   core_* : 128-bit packed plaintext block out to the cipher core
//   res_*  : 128-bit ciphertext block back from the cipher core
//   ct_*   : 32-bit ciphertext words out to the sink streamer
// slave  = adapter view, master = environment (streamers + core) view.
interface aes_block_adapter_if #(
   parameter int DW = 32,
   parameter int BW = 128
) ();
   logic            pt_valid_i;
   logic            pt_ready_o;
   logic [DW-1:0]   pt_data_i;
   logic [DW/8-1:0] pt_strb_i;
   logic            core_valid_o;
   logic            core_ready_i;
   logic [BW-1:0]   core_data_o;
   logic            res_valid_i;
   logic            res_ready_o;
   logic [BW-1:0]   res_data_i;
   logic            ct_valid_o;
   logic            ct_ready_i;
   logic [DW-1:0]   ct_data_o;
   logic [DW/8-1:0] ct_strb_o;

   modport slave (
      input  pt_valid_i, pt_data_i, pt_strb_i,
      output pt_ready_o,
      output core_valid_o, core_data_o,
      input  core_ready_i,
      input  res_valid_i, res_data_i,
      output res_ready_o,
      output ct_valid_o, ct_data_o, ct_strb_o,
      input  ct_ready_i
   );

   modport master (
      output pt_valid_i, pt_data_i, pt_strb_i,
      input  pt_ready_o,
      input  core_valid_o, core_data_o,
      output core_ready_i,
      output res_valid_i, res_data_i,
      input  res_ready_o,
      input  ct_valid_o, ct_data_o, ct_strb_o,
      output ct_ready_i
   );
endinterface

// File: rtl/aes_block_adapter.sv
// Stream-to-block adapter between the HWPE streamers and the AES core.
// Packs 4 plaintext words into a 128-bit block, hands it to the core,
// captures the ciphertext block and serialises it back into 4 words.
// Ports:
//   clk, reset_n       clock, async active-low reset
//   clear_i            synchronous clear back to IDLE
//   enable_i           gates plaintext acceptance and job start
//   start_i            one-cycle job start, nblocks_i sampled with it
//   bus                stream/core handshakes (aes_block_adapter_if.slave)
//   busy_o, done_o     engine flags (not idle / one-cycle job end)
//   err_o              sticky: a plaintext word had a partial byte strobe
//
// state   | meaning
// IDLE    | waiting for an accepted start
// FILL    | collecting plaintext words into the block register
// ISSUE   | offering the packed block to the core
// WAIT    | waiting for the ciphertext block from the core
// DRAIN   | emitting the 4 ciphertext words
// DONE    | one-cycle done pulse, then back to IDLE
module aes_block_adapter #(
   parameter int DW    = 32,
   parameter int BW    = 128,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear_i,
   input  logic             enable_i,
   input  logic             start_i,
   input  logic [CNT_W-1:0] nblocks_i,
   aes_block_adapter_if.slave bus,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o
);
   localparam int WPB = BW / DW;
   localparam int WW  = $clog2(WPB);

   typedef enum logic [2:0] {
      S_IDLE, S_FILL, S_ISSUE, S_WAIT, S_DRAIN, S_DONE
   } state_t;

   state_t                   state_q;
   logic [WW-1:0]            wcnt_q;
   logic [CNT_W-1:0]         bcnt_q;
   logic [CNT_W-1:0]         nblk_q;
   logic [CNT_W-1:0]         bcnt_inc;
   logic [WPB-1:0][DW-1:0]   blk_q;
   logic [WPB-1:0][DW-1:0]   out_q;
   logic                     err_q;
   logic                     pt_hs;
   logic                     ct_valid;

   assign bcnt_inc = bcnt_q + CNT_W'(1);
   assign pt_hs    = (state_q == S_FILL) && enable_i && bus.pt_valid_i;

   // Word k of a block lives in packed slot WPB-1-k (first word on top);
   // with WPB a power of two that index is simply ~k.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         wcnt_q  <= '0;
         bcnt_q  <= '0;
         nblk_q  <= '0;
         blk_q   <= '0;
         out_q   <= '0;
         err_q   <= 1'b0;
      end else if (clear_i) begin
         // data registers deliberately keep their contents
         state_q <= S_IDLE;
         wcnt_q  <= '0;
         bcnt_q  <= '0;
         nblk_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i && enable_i) begin
                  bcnt_q  <= '0;
                  wcnt_q  <= '0;
                  err_q   <= 1'b0;
                  nblk_q  <= nblocks_i;
                  state_q <= (nblocks_i == '0) ? S_DONE : S_FILL;
               end
            end
            S_FILL: begin
               if (pt_hs) begin
                  blk_q[~wcnt_q] <= bus.pt_data_i;
                  if (bus.pt_strb_i != '1) err_q <= 1'b1;
                  wcnt_q <= wcnt_q + WW'(1);
                  if (wcnt_q == WW'(WPB-1)) state_q <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (bus.core_ready_i) state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (bus.res_valid_i) begin
                  out_q   <= bus.res_data_i;
                  wcnt_q  <= '0;
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (bus.ct_ready_i) begin
                  wcnt_q <= wcnt_q + WW'(1);
                  if (wcnt_q == WW'(WPB-1)) begin
                     bcnt_q  <= bcnt_inc;
                     state_q <= (bcnt_inc == nblk_q) ? S_DONE : S_FILL;
                  end
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ct_valid         = (state_q == S_DRAIN);
   assign bus.pt_ready_o   = (state_q == S_FILL) && enable_i;
   assign bus.core_valid_o = (state_q == S_ISSUE);
   assign bus.core_data_o  = blk_q;
   assign bus.res_ready_o  = (state_q == S_WAIT);
   assign bus.ct_valid_o   = ct_valid;
   assign bus.ct_data_o    = out_q[~wcnt_q];
   assign bus.ct_strb_o    = {(DW/8){ct_valid}};
   assign busy_o           = (state_q != S_IDLE);
   assign done_o           = (state_q == S_DONE);
   assign err_o            = err_q;
endmodule

// File: tb/tb_aes_block_adapter.sv
module tb_aes_block_adapter;
   localparam int DW    = 32;
   localparam int BW    = 128;
   localparam int CNT_W = 16;
   localparam int WPB   = 4;
   localparam int BUDGET = 3000;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             clear_i = 1'b0;
   logic             enable_i = 1'b0;
   logic             start_i = 1'b0;
   logic [CNT_W-1:0] nblocks_i = '0;
   logic             busy_o, done_o, err_o;

   aes_block_adapter_if #(.DW(DW), .BW(BW)) bus ();

   aes_block_adapter #(.DW(DW), .BW(BW), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear_i   (clear_i),
      .enable_i  (enable_i),
      .start_i   (start_i),
      .nblocks_i (nblocks_i),
      .bus       (bus.slave),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .err_o     (err_o)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [DW-1:0] vec [WPB] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};

   typedef struct {
      logic [CNT_W-1:0] nb;
      int               gap;       // % chance of a bubble on each handshake
      int               bad_word;  // job word index sent with strobe 0111, -1 none
      int               clr_at;    // clear after this many ct words, 0 none
      logic             exp_err;
      logic             exp_done;
   } job_t;

   job_t jobs [7];

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_evt(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: unexpected event, expected none", name);
   endtask

   // Stand-in for the cipher: the FIPS-197 AES-128 example for the
   // reference plaintext, an arbitrary reversible scramble otherwise.
   function automatic logic [BW-1:0] core_fn(input logic [BW-1:0] b);
      if (b == 128'h00112233445566778899aabbccddeeff)
         return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      return {b[63:0], b[127:64]} ^ 128'h0123456789abcdef_fedcba9876543210;
   endfunction

   task automatic run_job(input job_t jb, input bit use_vec);
      logic [DW-1:0] pt_q [$];
      logic [3:0]    st_q [$];
      logic [BW-1:0] core_exp [$];
      logic [BW-1:0] res_q [$];
      logic [DW-1:0] ct_exp [$];
      logic [BW-1:0] blk, r, exp_b;
      logic [DW-1:0] d, p_ct_data;
      logic [BW-1:0] p_core_data;
      int nw, pt_sent, ct_seen, dones, cyc, last_ct_cyc, done_cyc, clr_cyc, tail;
      bit hs_pt, hs_core, hs_res, hs_ct, cleared;
      bit p_pt_last, p_core_hs, p_res_hs, p_core_hold, p_ct_hold;

      nw = int'(jb.nb) * WPB;
      pt_sent = 0; ct_seen = 0; dones = 0; cyc = 0;
      last_ct_cyc = -10; done_cyc = -10; clr_cyc = -10; tail = -1;
      cleared = 0; p_pt_last = 0; p_core_hs = 0; p_res_hs = 0;
      p_core_hold = 0; p_ct_hold = 0; p_ct_data = '0; p_core_data = '0;
      blk = '0;

      // Reference: blocks are 4 consecutive words, first word on top;
      // ciphertext words are the core result split top-first.
      for (int w = 0; w < nw; w++) begin
         d = use_vec ? vec[w % WPB] : $urandom;
         pt_q.push_back(d);
         st_q.push_back((w == jb.bad_word) ? 4'b0111 : 4'hf);
         blk = {blk[BW-DW-1:0], d};
         if (w % WPB == WPB-1) begin
            core_exp.push_back(blk);
            r = core_fn(blk);
            for (int k = 0; k < WPB; k++) ct_exp.push_back(r[BW-1-k*DW -: DW]);
         end
      end

      @(posedge clk); #1;
      enable_i = 1'b1; start_i = 1'b1; nblocks_i = jb.nb;
      @(posedge clk); #1;
      start_i = 1'b0;

      while (cyc < BUDGET && tail != 0) begin
         @(negedge clk);
         hs_pt   = bus.pt_valid_i && bus.pt_ready_o;
         hs_core = bus.core_valid_o && bus.core_ready_i;
         hs_res  = bus.res_valid_i && bus.res_ready_o;
         hs_ct   = bus.ct_valid_o && bus.ct_ready_i;

         if (cyc == 0) begin
            chk("err_cleared_by_start", err_o, 1'b0);
            chk("busy_after_start", busy_o, 1'b1);
         end
         if (!enable_i) chk("pt_ready_gated_by_enable", bus.pt_ready_o, 1'b0);
         if (p_pt_last) chk("core_valid_after_fill", bus.core_valid_o, 1'b1);
         if (p_core_hs) chk("res_ready_after_issue", bus.res_ready_o, 1'b1);
         if (p_res_hs)  chk("ct_valid_after_result", bus.ct_valid_o, 1'b1);
         if (p_core_hold) begin
            chk("core_valid_held", bus.core_valid_o, 1'b1);
            chk("core_data_stable", bus.core_data_o, p_core_data);
         end
         if (p_ct_hold) begin
            chk("ct_valid_held", bus.ct_valid_o, 1'b1);
            chk("ct_data_stable", bus.ct_data_o, p_ct_data);
         end

         if (hs_pt) begin
            pt_sent++;
            void'(pt_q.pop_front());
            void'(st_q.pop_front());
         end
         if (hs_core) begin
            if (core_exp.size() == 0) fail_evt("core_extra_block");
            else begin
               exp_b = core_exp.pop_front();
               chk("core_data", bus.core_data_o, exp_b);
               res_q.push_back(core_fn(exp_b));
            end
         end
         if (hs_res && res_q.size() > 0) void'(res_q.pop_front());
         if (hs_ct) begin
            if (ct_exp.size() == 0) fail_evt("ct_extra_word");
            else chk("ct_data", bus.ct_data_o, ct_exp.pop_front());
            chk("ct_strb", bus.ct_strb_o, 4'hf);
            ct_seen++;
            last_ct_cyc = cyc;
         end
         if (done_o) begin
            dones++;
            if (dones == 1) begin
               chk("done_follows_last_ct", cyc - last_ct_cyc, 1);
               chk("ct_words_at_done", ct_seen, nw);
               chk("err_at_done", err_o, jb.exp_err);
               done_cyc = cyc;
               tail = 3;
            end
         end
         if (dones > 0 && cyc == done_cyc + 1) chk("busy_low_after_done", busy_o, 1'b0);
         if (cleared && cyc == clr_cyc + 2) begin
            chk("clear_busy", busy_o, 1'b0);
            chk("clear_pt_ready", bus.pt_ready_o, 1'b0);
            chk("clear_core_valid", bus.core_valid_o, 1'b0);
            chk("clear_res_ready", bus.res_ready_o, 1'b0);
            chk("clear_ct_valid", bus.ct_valid_o, 1'b0);
            chk("clear_done", done_o, 1'b0);
            chk("clear_err", err_o, 1'b0);
            tail = 5;
         end

         p_pt_last   = hs_pt && (pt_sent % WPB == 0);
         p_core_hs   = hs_core;
         p_res_hs    = hs_res;
         p_core_hold = bus.core_valid_o && !bus.core_ready_i && !clear_i;
         p_core_data = bus.core_data_o;
         p_ct_hold   = bus.ct_valid_o && !bus.ct_ready_i && !clear_i;
         p_ct_data   = bus.ct_data_o;

         @(posedge clk); #1;
         clear_i  = 1'b0;
         enable_i = (jb.gap == 0) ? 1'b1 : ($urandom_range(99) >= 10);
         start_i  = (jb.gap != 0) && (dones == 0) && ($urandom_range(99) < 5);
         if (start_i) nblocks_i = CNT_W'($urandom);
         bus.core_ready_i = (jb.gap == 0) || ($urandom_range(99) >= jb.gap);
         bus.ct_ready_i   = (jb.gap == 0) || ($urandom_range(99) >= jb.gap);
         if (jb.clr_at > 0 && !cleared && ct_seen == jb.clr_at) begin
            clear_i = 1'b1;
            cleared = 1;
            clr_cyc = cyc;
            enable_i = 1'b1;
            bus.ct_ready_i = 1'b0;
         end
         if (hs_pt || !bus.pt_valid_i) begin
            if (pt_q.size() > 0 && (jb.gap == 0 || $urandom_range(99) >= jb.gap)) begin
               bus.pt_valid_i = 1'b1;
               bus.pt_data_i  = pt_q[0];
               bus.pt_strb_i  = st_q[0];
            end else bus.pt_valid_i = 1'b0;
         end
         if (hs_res || !bus.res_valid_i) begin
            if (res_q.size() > 0 && (jb.gap == 0 || $urandom_range(99) >= jb.gap)) begin
               bus.res_valid_i = 1'b1;
               bus.res_data_i  = res_q[0];
            end else bus.res_valid_i = 1'b0;
         end
         if (tail > 0) tail--;
         cyc++;
      end

      if (tail != 0) fail_evt("job_timeout");
      chk("done_pulses", dones, jb.exp_done ? 1 : 0);
      if (jb.exp_done) chk("core_blocks_outstanding", core_exp.size(), 0);

      bus.pt_valid_i = 1'b0; bus.res_valid_i = 1'b0;
      bus.core_ready_i = 1'b0; bus.ct_ready_i = 1'b0;
      start_i = 1'b0; clear_i = 1'b0; enable_i = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      jobs[0] = '{nb: 16'd1, gap: 0,  bad_word: -1, clr_at: 0, exp_err: 1'b0, exp_done: 1'b1};
      jobs[1] = '{nb: 16'd2, gap: 40, bad_word: -1, clr_at: 0, exp_err: 1'b0, exp_done: 1'b1};
      jobs[2] = '{nb: 16'd1, gap: 0,  bad_word: 2,  clr_at: 0, exp_err: 1'b1, exp_done: 1'b1};
      jobs[3] = '{nb: 16'd2, gap: 30, bad_word: -1, clr_at: 0, exp_err: 1'b0, exp_done: 1'b1};
      jobs[4] = '{nb: 16'd1, gap: 0,  bad_word: -1, clr_at: 2, exp_err: 1'b0, exp_done: 1'b0};
      jobs[5] = '{nb: 16'd1, gap: 0,  bad_word: -1, clr_at: 0, exp_err: 1'b0, exp_done: 1'b1};
      jobs[6] = '{nb: 16'd3, gap: 50, bad_word: 5,  clr_at: 0, exp_err: 1'b1, exp_done: 1'b1};

      bus.pt_valid_i = 1'b0; bus.pt_data_i = '0; bus.pt_strb_i = '1;
      bus.core_ready_i = 1'b0; bus.res_valid_i = 1'b0; bus.res_data_i = '0;
      bus.ct_ready_i = 1'b0;
      enable_i = 1'b1;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_done", done_o, 1'b0);
      chk("rst_err", err_o, 1'b0);
      chk("rst_pt_ready", bus.pt_ready_o, 1'b0);
      chk("rst_core_valid", bus.core_valid_o, 1'b0);
      chk("rst_res_ready", bus.res_ready_o, 1'b0);
      chk("rst_ct_valid", bus.ct_valid_o, 1'b0);
      chk("rst_core_data", bus.core_data_o, '0);
      chk("rst_ct_data", bus.ct_data_o, '0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // nblocks = 0: immediate done, no data handshakes offered
      @(posedge clk); #1;
      bus.pt_valid_i = 1'b1; start_i = 1'b1; nblocks_i = '0;
      @(posedge clk); #1;
      start_i = 1'b0;
      @(negedge clk);
      chk("nb0_done", done_o, 1'b1);
      chk("nb0_pt_ready", bus.pt_ready_o, 1'b0);
      chk("nb0_core_valid", bus.core_valid_o, 1'b0);
      chk("nb0_ct_valid", bus.ct_valid_o, 1'b0);
      @(negedge clk);
      chk("nb0_done_one_cycle", done_o, 1'b0);
      chk("nb0_idle", busy_o, 1'b0);
      chk("nb0_pt_ready_idle", bus.pt_ready_o, 1'b0);
      @(posedge clk); #1;
      bus.pt_valid_i = 1'b0;

      for (int j = 0; j < 7; j++) run_job(jobs[j], j == 0);

      // asynchronous reset mid-job abandons it silently
      @(posedge clk); #1;
      start_i = 1'b1; nblocks_i = 16'd1;
      bus.pt_valid_i = 1'b1; bus.pt_data_i = 32'hdeadbeef; bus.pt_strb_i = '1;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      chk("arst_busy", busy_o, 1'b0);
      chk("arst_core_data", bus.core_data_o, '0);
      chk("arst_done", done_o, 1'b0);
      bus.pt_valid_i = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("arst_no_done", done_o, 1'b0);
         chk("arst_stays_idle", busy_o, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
